// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: the one-bit full adder
// and the elaboration-time legality check on the slice split.
package adder_pkg;

  // Returns {carry_out, sum} of a one-bit full add.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder built from a full_add chain;
// one instance per pipeline stage.
module rca_slice
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  always_comb begin
    logic c;
    // NOTE: blocking assignments here so each bit sees the carry just produced
    // by the bit below it within the same evaluation.
    c = ci_i;
    for (int i = 0; i < W; i++) begin
      {c, s_o[i]} = full_add(a_i[i], b_i[i], c);
    end
    co_o = c;
  end

endmodule

// File: rtl/seq_ripple_adder_pipe.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor: STAGES slices with the
// carry registered between them, valid/ready flow control and a sticky overflow.
module seq_ripple_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;
  localparam bit SPLIT_OK = split_ok(WIDTH, STAGES);

  if (!SPLIT_OK) begin : g_bad_split
    $error("seq_ripple_adder_pipe: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] adv;
  logic              run_q;
  logic              sticky_q, sticky_d;
  logic              out_hs;

  // Stage k may hand its beat on when any slot from k+1 to the output is free
  // or the output is being taken; this is the unrolled ready chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    localparam logic [STAGES-1:0] LOW = STAGES'((64'd1 << (k + 1)) - 64'd1);
    assign adv[k] = out_ready || !(&(v_all | LOW));
  end

  assign in_ready = run_q && (!v_all[0] || adv[0]);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int SW = WIDTH - LO;   // operand bits not yet added on entry
    localparam int UW = SW - SLICE;   // operand bits left for later stages

    logic [SW-1:0]      a_src, b_src;
    logic               ci, vin, am_in, bm_in, en;
    logic [SLICE-1:0]   slice_s;
    logic               slice_co;
    logic [LO+SLICE-1:0] s_d, s_q;
    logic               v_q, c_q, am_q, bm_q;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b ^ {WIDTH{sub}};
      assign ci    = sub | cin;
      assign vin   = in_valid && in_ready;
      assign am_in = a_src[SW-1];
      assign bm_in = b_src[SW-1];
      assign s_d   = slice_s;
    end else begin : g_body
      assign a_src = g_stage[k-1].g_up.a_up_q;
      assign b_src = g_stage[k-1].g_up.b_up_q;
      assign ci    = g_stage[k-1].c_q;
      assign vin   = g_stage[k-1].v_q;
      assign am_in = g_stage[k-1].am_q;
      assign bm_in = g_stage[k-1].bm_q;
      assign s_d   = {slice_s, g_stage[k-1].s_q};
    end

    rca_slice #(.W(SLICE)) u_slice (
      .a_i  (a_src[SLICE-1:0]),
      .b_i  (b_src[SLICE-1:0]),
      .ci_i (ci),
      .s_o  (slice_s),
      .co_o (slice_co)
    );

    assign en       = !v_q || adv[k];
    assign v_all[k] = v_q;

    // NOTE: the datapath registers are reset as well as the valid bits, so the
    // output bus reads zero after reset rather than stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        am_q <= 1'b0;
        bm_q <= 1'b0;
        s_q  <= '0;
      end else if (en) begin
        // NOTE: non-blocking assignments for all registered state, so every
        // stage samples its predecessor's pre-edge value.
        v_q <= vin;
        if (vin) begin
          c_q  <= slice_co;
          am_q <= am_in;
          bm_q <= bm_in;
          s_q  <= s_d;
        end
      end
    end

    if (UW > 0) begin : g_up
      logic [UW-1:0] a_up_q, b_up_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (en && vin) begin
          a_up_q <= a_src[SW-1:SLICE];
          b_up_q <= b_src[SW-1:SLICE];
        end
      end
    end
  end

  assign out_valid = v_all[LAST];
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  assign ovf       = (g_stage[LAST].am_q == g_stage[LAST].bm_q) &&
                     (sum[MSB] != g_stage[LAST].am_q);
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    sticky_d = sticky_q;
    if (out_hs && ovf) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_seq_ripple_adder_pipe.sv
// Bench for seq_ripple_adder_pipe: directed vectors, an arithmetic reference
// model with an in-order scoreboard, and literal expectations for key cases.
module tb_seq_ripple_adder_pipe;

  localparam int W  = 32;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic          cin = 1'b0, sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout, ovf, ovf_sticky;
  logic          clr_sticky = 1'b0;

  always #5 clk = ~clk;

  seq_ripple_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  int   rdy_mode = 0;   // 0: out_ready high, 1: toggle each cycle, 2: low
  bit   low_seen = 1'b0;
  exp_t exp_q[$];
  exp_t e;
  logic sticky_m = 1'b0;
  logic held_v = 1'b0;
  logic [W-1:0] held_s;
  logic held_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic: signed range test for overflow, unsigned compare for carry.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t r;
    longint sa, sb, sr;
    longint unsigned ua, ub, ur;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sv) begin
      sr  = sa - sb;
      ur  = ua - ub;
      r.c = (ua >= ub);
    end else begin
      sr  = sa + sb + longint'(cv);
      ur  = ua + ub + longint'(cv);
      r.c = ur[32];
    end
    r.s = ur[W-1:0];
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      sticky_m = 1'b0;
      held_v   = 1'b0;
    end else begin
      check("ovf_sticky", ovf_sticky, sticky_m);
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, held_s);
        check("hold_cout", cout, held_c);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("ovf", ovf, e.o);
          if (e.o) sticky_m = 1'b1;
          else if (clr_sticky) sticky_m = 1'b0;
        end
      end else if (clr_sticky) begin
        sticky_m = 1'b0;
      end
      held_v = out_valid && !out_ready;
      held_s = sum;
      held_c = cout;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic cv, input logic sv);
    bit done = 1'b0;
    a = av; b = bv; cin = cv; sub = sv;
    in_valid = 1'b1;
    for (int g = 0; g < 40 && !done; g++) begin
      if (in_ready) done = 1'b1;
      else low_seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    int g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] s_e,
                            input logic c_e, input logic o_e);
    wait_valid({name, "_valid"});
    check({name, "_sum"}, sum, s_e);
    check({name, "_cout"}, cout, c_e);
    check({name, "_ovf"}, ovf, o_e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int base;
    int g;
    logic [W-1:0] s0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    tick();
    check("in_ready_after_edge", in_ready, 1);

    // Carry ripples through every slice; latency counted from the accept edge.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, ST);
    check("t1_sum", sum, 32'h0000_0000);
    check("t1_cout", cout, 1);
    check("t1_ovf", ovf, 0);
    tick();

    // Subtract mode.
    send(32'd5, 32'd7, 1'b1, 1'b1);
    expect_out("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    expect_out("sub_min_1", 32'h7FFF_FFFF, 1'b1, 1'b1);
    check("sticky_set", ovf_sticky, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_clr", ovf_sticky, 0);

    // Back-to-back beats under alternating backpressure.
    rdy_mode = 1;
    base = out_cnt;
    low_seen = 1'b0;
    for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
    rdy_mode = 0;
    g = 0;
    while ((exp_q.size() > 0 || out_valid) && g < 50) begin
      tick();
      g++;
    end
    check("b2b_count", out_cnt - base, 8);
    check("b2b_in_ready_dropped", low_seen, 1);

    // Full pipe held by backpressure, then drained.
    rdy_mode = 2;
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    s0 = sum;
    check("full_head_sum", s0, 32'h8000_0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_sum", sum, 32'h8000_0000);
      check("stall_ovf", ovf, 1);
      check("stall_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      check("drain_consecutive", out_valid, 1);
      tick();
    end
    check("drain_empty", out_valid, 0);
    check("sticky_before_reset", ovf_sticky, 1);

    // Reset with beats in flight.
    rdy_mode = 2;
    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0, 1'b0);
    send(32'd3, 32'd4, 1'b1, 1'b0);
    send(32'd10, 32'd3, 1'b0, 1'b1);
    tick();
    check("preflush_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_sum", sum, 0);
    check("flush_cout", cout, 0);
    check("flush_sticky", ovf_sticky, 0);
    check("flush_in_ready", in_ready, 0);
    tick();
    tick();
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale_out", out_valid, 0);
    end
    check("post_reset_in_ready", in_ready, 1);

    // Overflow handshake and clear in the same cycle: set wins.
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    wait_valid("race_valid");
    clr_sticky = 1'b1;
    tick();
    check("race_sticky_set_wins", ovf_sticky, 1);
    tick();
    check("race_sticky_cleared", ovf_sticky, 0);
    clr_sticky = 1'b0;
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ripple_adder_pipe.md
Name: seq_ripple_adder_pipe

Overview:
Parametrised, pipelined successor to the combinational ripple-carry adder. It splits a WIDTH-bit add into STAGES ripple-carry slices, with carry and partial sums registered between slices, so throughput is one add per cycle. A valid/ready handshake on input and output allows backpressure. Optional subtract mode and a sticky overflow flag are added.

Parameters:
WIDTH, 32, operand width in bits (>=2).
STAGES, 4, number of pipeline slices; WIDTH must be divisible by STAGES.
SLICE, WIDTH/STAGES, derived local: bits per slice.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (ignored when sub=1)
sub  in  1  1: compute a-b (b inverted, carry-in forced to 1)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry-out (for subtract: 1 = no borrow)
ovf  out  1  signed overflow of this result
ovf_sticky  out  1  OR of ovf over all accepted results since reset/clear
clr_sticky  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, ovf_sticky=0. in_ready goes to 1 on the first edge after deassertion.
- Input accept: in_valid && in_ready. a, b^{WIDTH{sub}} and carry (sub ? 1 : cin) are captured into stage 0.
- Stage k (0..STAGES-1): ripple-adds bits [k*SLICE +: SLICE] using the carry from stage k-1. The result slice is written into the stage register. Untouched upper operand bits are carried forward and lower result bits pass through.
- Latency: STAGES cycles from accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Pipeline control: a per-stage valid bit. Stage k advances when its downstream slot is empty or advancing, i.e. ready_k = !valid_{k+1} || ready_{k+1}. The last stage uses out_ready. in_ready = ready_0, which is combinational from out_ready through the valid chain.
- Output regs: sum, cout and ovf hold stable while out_valid && !out_ready. They do not change until the handshake completes.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). The MSBs travel with the beat.
- ovf_sticky is set when an output handshake occurs with ovf=1. If clr_sticky and that set happen in the same cycle, the set wins.
- No beat may be lost or duplicated under any out_ready pattern. Order is preserved.
- Reset asserted mid-operation flushes all in-flight beats immediately. No partial result appears after reset.
- Boundary: WIDTH=STAGES (SLICE=1) must be legal. STAGES=1 degenerates to a single registered adder with latency 1.

Decomposition:
- Package adder_pkg: function full_add(a,b,c) returning {cout,s}; a localparam check that WIDTH % STAGES == 0.
- One sub-module, rca_slice, is natural: a combinational SLICE-bit ripple-carry adder (a, b, ci -> s, co) built from the full_add chain. It is instantiated per stage via generate.

Test Plan:
- WIDTH=32, STAGES=4, no backpressure: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, arriving 4 cycles after accept.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, ovf_sticky=1.
- Back-to-back 8 beats (a=i, b=i) with out_ready toggling 1010... -> sums 0,2,4,...,14 in order, none lost. in_ready drops when the pipe is full.
- out_ready=0 for 10 cycles with the pipe full -> sum/cout held constant, in_ready=0. Releasing drains 4 results on consecutive cycles.
- Assert rst_n low while 3 beats are in flight -> out_valid=0 immediately. After release, no stale result appears and ovf_sticky=0.
- clr_sticky concurrent with an overflowing output handshake -> ovf_sticky stays 1. The next cycle with clr_sticky alone -> 0.
